// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcode constants, sequencer state encoding and control-strobe bundle.
// Ports: none (package).
package cpu_ctrl_pkg;
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] ALU_ADD = 5'b00011;

    typedef enum logic [4:0] {
        S_RST, S_F0, S_F1, S_F2, S_DEC,
        S_LDI_T3, S_LDI_T4, S_LDI_T5,
        S_LD_T3, S_LD_T4, S_LD_T5, S_LD_T6, S_LD_T7,
        S_ST_T3, S_ST_T4, S_ST_T5, S_ST_T6, S_ST_T7,
        S_BR_T3, S_BR_T4, S_BR_T5, S_BR_T6,
        S_HALT
    } state_t;

    // Field order matches the top-level output concatenation.
    typedef struct packed {
        logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
        logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, con_in, outport_in;
        logic inc_pc, gra, grb, grc, r_in, r_out, ba_out;
        logic mem_read, mem_write, mem_en;
    } ctrl_t;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles in a memory-wait state, qualifies memory_done and flags timeouts.
// Ports: clk_i/rst_i (async active-high), wait_i (in a wait state), memory_done_i;
//        done_o (qualified completion), timeout_o (limit hit this cycle), first_o (first wait cycle),
//        mem_timeout_o (sticky until reset).
module mem_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wait_i,
    input  logic memory_done_i,
    output logic done_o,
    output logic timeout_o,
    output logic first_o,
    output logic mem_timeout_o
);
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic mem_timeout_q, mem_timeout_d;
    // A completion on the limit cycle wins over the timeout.
    assign done_o = wait_i & memory_done_i;
    assign timeout_o = wait_i & ~memory_done_i & (cnt_q == CW'(MEM_WAIT_MAX - 1));
    assign first_o = cnt_q == '0;
    assign mem_timeout_o = mem_timeout_q;
    // No two wait states are adjacent, so clearing outside waits restarts the count on entry.
    assign cnt_d = (wait_i && !memory_done_i && !timeout_o) ? cnt_q + CW'(1) : '0;
    assign mem_timeout_d = mem_timeout_q | timeout_o;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit for the CPU datapath.
// Ports: Clock, clear (async active-high), IR, con_ff_bit, memory_done in;
//        bus source selects, register load enables, register-select, memory controls,
//        opcode (ALU op), run, illegal_op (1-cycle pulse), mem_timeout (sticky) out.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] IR,
    input  logic                  con_ff_bit,
    input  logic                  memory_done,
    output logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
    output logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
    output logic IncPC, Gra, Grb, Grc, Rin, Rout, BAout,
    output logic Mem_Read, Mem_Write, Mem_enable512x32,
    output logic [4:0]            opcode,
    output logic                  run,
    output logic                  illegal_op,
    output logic                  mem_timeout
);
    state_t state_q, state_d;
    logic illegal_q, illegal_d;
    logic done, timeout, first;
    ctrl_t c;
    logic [4:0] alu;
    logic ir_unused;
    assign ir_unused = ^IR[DATA_WIDTH-6:0];

    mem_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_timer (
        .clk_i         (Clock),
        .rst_i         (clear),
        .wait_i        (state_q inside {S_F1, S_LD_T6, S_ST_T7}),
        .memory_done_i (memory_done),
        .done_o        (done),
        .timeout_o     (timeout),
        .first_o       (first),
        .mem_timeout_o (mem_timeout)
    );

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_RST:    state_d = S_F0;
            S_F0:     state_d = S_F1;
            S_F1:     state_d = timeout ? S_HALT : (done ? S_F2 : S_F1);
            S_F2:     state_d = S_DEC;
            S_DEC: begin
                case (IR[DATA_WIDTH-1 -: 5])
                    OP_LD:   state_d = S_LD_T3;
                    OP_LDI:  state_d = S_LDI_T3;
                    OP_ST:   state_d = S_ST_T3;
                    OP_BR:   state_d = S_BR_T3;
                    OP_HALT: state_d = S_HALT;
                    default: begin
                        state_d = S_F0;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_LDI_T3: state_d = S_LDI_T4;
            S_LDI_T4: state_d = S_LDI_T5;
            S_LDI_T5: state_d = S_F0;
            S_LD_T3:  state_d = S_LD_T4;
            S_LD_T4:  state_d = S_LD_T5;
            S_LD_T5:  state_d = S_LD_T6;
            S_LD_T6:  state_d = timeout ? S_HALT : (done ? S_LD_T7 : S_LD_T6);
            S_LD_T7:  state_d = S_F0;
            S_ST_T3:  state_d = S_ST_T4;
            S_ST_T4:  state_d = S_ST_T5;
            S_ST_T5:  state_d = S_ST_T6;
            S_ST_T6:  state_d = S_ST_T7;
            S_ST_T7:  state_d = timeout ? S_HALT : (done ? S_F0 : S_ST_T7);
            S_BR_T3:  state_d = S_BR_T4;
            S_BR_T4:  state_d = S_BR_T5;
            S_BR_T5:  state_d = S_BR_T6;
            S_BR_T6:  state_d = S_F0;
            default:  state_d = S_HALT;
        endcase
    end

    always_comb begin
        c = '0;
        alu = '0;
        case (state_q)
            S_F0: begin
                c.pc_out = 1'b1; c.inc_pc = 1'b1; c.mar_in = 1'b1; c.z_in = 1'b1;
            end
            S_F1: begin
                // PC is written back only once even if the fetch stalls.
                c.zlo_out = 1'b1; c.pc_in = first; c.mdr_in = 1'b1;
                c.mem_read = 1'b1; c.mem_en = 1'b1;
            end
            S_F2: begin
                c.mdr_out = 1'b1; c.ir_in = 1'b1;
            end
            S_LDI_T3, S_LD_T3, S_ST_T3: begin
                c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
            end
            S_LDI_T4, S_LD_T4, S_ST_T4, S_BR_T5: begin
                c.c_out = 1'b1; c.z_in = 1'b1; alu = ALU_ADD;
            end
            S_LDI_T5, S_LD_T7: begin
                c.zlo_out = state_q == S_LDI_T5; c.mdr_out = state_q == S_LD_T7;
                c.gra = 1'b1; c.r_in = 1'b1;
            end
            S_LD_T5, S_ST_T5: begin
                c.zlo_out = 1'b1; c.mar_in = 1'b1;
            end
            S_LD_T6: begin
                c.mem_read = 1'b1; c.mdr_in = 1'b1; c.mem_en = 1'b1;
            end
            S_ST_T6: begin
                c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
            end
            S_ST_T7: begin
                c.mem_write = 1'b1; c.mem_en = 1'b1;
            end
            S_BR_T3: begin
                c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1;
            end
            S_BR_T4: begin
                c.pc_out = 1'b1; c.y_in = 1'b1;
            end
            S_BR_T6: begin
                c.zlo_out = 1'b1; c.pc_in = con_ff_bit;
            end
            default: ;
        endcase
    end

    assign {HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
            MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in,
            IncPC, Gra, Grb, Grc, Rin, Rout, BAout,
            Mem_Read, Mem_Write, Mem_enable512x32} = c;
    assign opcode = alu;
    assign run = !(state_q inside {S_RST, S_HALT});
    assign illegal_op = illegal_q;
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the CPU datapath (`System`). Drives the same control strobes the System benches drive by hand.
- Runs fetch, then decodes IR[31:27] and runs a fixed T-state sequence for ldi, ld, st, branch (brzr/brnz/brpl/brmi), halt and illegal opcodes.
- Sits between the IR/CON_FF/memory-done outputs of the datapath and every datapath control input. It replaces testbench-driven sequencing.

Parameters:
- DATA_WIDTH, 32, instruction/IR width.
- MEM_WAIT_MAX, 15, maximum cycles to wait for memory_done before flagging mem_timeout.

Ports:
- Clock  in  1  system clock, rising edge.
- clear  in  1  reset, asynchronous, active-high.
- IR  in  DATA_WIDTH  instruction register contents; opcode is IR[31:27].
- con_ff_bit  in  1  branch condition flip-flop from datapath.
- memory_done  in  1  memory access complete, valid while Mem_enable512x32=1.
- HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout  out  1 each  bus source selects.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in  out  1 each  register load enables.
- IncPC, Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  PC-increment and register-select controls.
- Mem_Read, Mem_Write, Mem_enable512x32  out  1 each  memory controls.
- opcode  out  5  ALU operation; 5'b00011 = ADD, otherwise 5'b00000.
- run  out  1  1 while executing, 0 when halted or in reset.
- illegal_op  out  1  one-cycle pulse on an undecoded opcode.
- mem_timeout  out  1  sticky until clear; memory wait exceeded MEM_WAIT_MAX.

Behaviour:
- Output decoding:
  - All outputs are Moore-decoded from the state register.
  - Exception: in BR_T6, PCin = con_ff_bit (combinational).
  - Any strobe not listed for a state is 0.
- Reset:
  - clear=1 forces state RST asynchronously.
  - All strobes, opcode, run, illegal_op and mem_timeout go to 0; the wait counter goes to 0.
  - A clear mid-sequence aborts the sequence with no further strobes.
  - First edge after clear deasserts: RST -> F0.
- Fetch:
  - F0: PCout, IncPC, MARin, Zin.
  - F1: Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32.
    - PCin asserts only on the first F1 cycle.
    - The state holds until memory_done=1.
  - F2: MDRout, IRin.
  - Then dispatch on IR[31:27] (value latched at F2; decoded in the next state).
- Dispatch state DEC (no strobes), keyed on IR[31:27]:
  - 00000 -> LD_T3; 00001 -> LDI_T3; 00010 -> ST_T3; 10011 -> BR_T3; 11011 -> HALT.
  - Any other opcode -> F0, with illegal_op pulsed 1 cycle.
- LDI:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, opcode=ADD.
  - T5: Zlo_out, Gra, Rin -> F0.
- LD:
  - T3 and T4 as LDI.
  - T5: Zlo_out, MARin.
  - T6: Mem_Read, MDRin, Mem_enable512x32; wait for memory_done.
  - T7: MDRout, Gra, Rin -> F0.
- ST:
  - T3 to T5 as LD.
  - T6: Gra, Rout, MDRin with Mem_Read=0 (MDR loads from bus).
  - T7: Mem_Write, Mem_enable512x32; wait for memory_done -> F0.
- BR:
  - T3: Gra, Rout, CONin.
  - T4: PCout, Yin.
  - T5: Cout, Zin, opcode=ADD.
  - T6: Zlo_out, PCin=con_ff_bit -> F0.
  - The not-taken case leaves PC at PC+1.
- HALT: run=0; absorbing until clear.
- Wait counter:
  - Counts cycles spent in any memory-wait state; resets on entering one.
  - If the count reaches MEM_WAIT_MAX without memory_done: set mem_timeout, go to HALT.
  - memory_done on the same edge as the limit wins (access completes, no timeout).
- Latency:
  - LDI 7 cycles, BR 8 cycles (fetch 3 + DEC + execute), with zero-wait memory (memory_done=1 in the first wait cycle).
  - LD and ST each take +1 cycle per wait cycle.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode constants OP_LD=5'b00000, OP_LDI=5'b00001, OP_ST=5'b00010, OP_BR=5'b10011, OP_HALT=5'b11011, ALU_ADD=5'b00011;
  - the state enum.
- One sub-module, mem_wait_timer: counter, memory_done qualification and timeout flag.

Test Plan:
- Reset: clear pulse at t=5ns, mid-F1 -> all strobes 0 immediately; F0 strobes (PCout=IncPC=MARin=Zin=1) on the first edge after release.
- LDI: IR=0x0A800000 (ldi r5,0), memory_done=1 -> F2 to LDI_T5 exact strobe sets; Zlo_out=Gra=Rin=1 in T5; total 7 cycles.
- Branch taken: IR=0x9A800001 (brzr r5,1), con_ff_bit=1 -> BR_T6 with Zlo_out=1, PCin=1; IR=0x9A880001 (brnz) with con_ff_bit=0 -> PCin=0 in T6.
- LD with 3-cycle memory latency -> LD_T6 held 3 cycles with Mem_Read=MDRin=Mem_enable512x32=1, then T7; ST similarly holds Mem_Write.
- Timeout: memory_done stuck 0 in F1 -> mem_timeout=1 after 15 cycles, run=0, HALT held; only clear recovers.
- Illegal opcode IR[31:27]=11111 -> illegal_op 1-cycle pulse, next state F0; IR opcode 11011 -> run=0 permanently.
